// File: rtl/scu_dsp_dma_bridge.sv
// SCU DSP DMA bridge: turns single-cycle DSP DMA strobes into level bus cycles, with a one-deep pending slot.
// Optional bus-wait timeout enabled by defining SCU_DSP_DMA_TIMEOUT_EN.
module scu_dsp_dma_bridge #(
  parameter int WAIT_MAX = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic [24:0] DSP_A,
  input  logic [31:0] DSP_DO,
  input  logic        DSP_WR,
  input  logic        DSP_REQ,
  output logic        DSP_ACK,
  output logic [31:0] DSP_DI,
  output logic [24:0] BUS_A,
  output logic [31:0] BUS_DO,
  input  logic [31:0] BUS_DI,
  output logic        BUS_WE,
  output logic        BUS_REQ,
  input  logic        BUS_RDY,
  output logic        BUSY,
  output logic        ERR,
  input  logic        ERR_CLR
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_ACK} state_t;

  state_t      state;
  logic        pend_v;
  logic [24:0] pend_a;
  logic [31:0] pend_do;
  logic        pend_wr;
  logic        tmo_hit;
  logic        err_set;

`ifdef SCU_DSP_DMA_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Counter is zero whenever the FSM is outside BUS, so every entry starts from 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt <= '0;
    end else if (CE_R) begin
      if (state != S_BUS) tmo_cnt <= '0;
      else if (!BUS_RDY)  tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign tmo_hit = (state == S_BUS) && !BUS_RDY && (tmo_cnt == 8'(WAIT_MAX - 1));
`else
  logic [31:0] unused_wait_max;
  assign unused_wait_max = WAIT_MAX;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    err_set = 1'b0;
    if (state == S_BUS && DSP_REQ && pend_v) err_set = 1'b1;
    if (tmo_hit)                             err_set = 1'b1;
  end

  assign BUSY = (state != S_IDLE) || pend_v;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      pend_v  <= 1'b0;
      pend_a  <= '0;
      pend_do <= '0;
      pend_wr <= 1'b0;
      DSP_ACK <= 1'b0;
      DSP_DI  <= '0;
      BUS_A   <= '0;
      BUS_DO  <= '0;
      BUS_WE  <= 1'b0;
      BUS_REQ <= 1'b0;
      ERR     <= 1'b0;
    end else if (CE_R) begin
      if (err_set)      ERR <= 1'b1;
      else if (ERR_CLR) ERR <= 1'b0;

      case (state)
        S_IDLE: begin
          if (DSP_REQ) begin
            BUS_A   <= DSP_A;
            BUS_DO  <= DSP_DO;
            BUS_WE  <= DSP_WR;
            BUS_REQ <= 1'b1;
            state   <= S_BUS;
          end
        end
        S_BUS: begin
          if (DSP_REQ && !pend_v) begin
            pend_v  <= 1'b1;
            pend_a  <= DSP_A;
            pend_do <= DSP_DO;
            pend_wr <= DSP_WR;
          end
          if (BUS_RDY) begin
            if (!BUS_WE) DSP_DI <= BUS_DI;
            BUS_REQ <= 1'b0;
            DSP_ACK <= 1'b1;
            state   <= S_ACK;
          end else if (tmo_hit) begin
            if (!BUS_WE) DSP_DI <= '1;
            BUS_REQ <= 1'b0;
            DSP_ACK <= 1'b1;
            state   <= S_ACK;
          end
        end
        S_ACK: begin
          DSP_ACK <= 1'b0;
          // Pending entry is older, so it wins; a coincident new request refills the slot.
          if (pend_v) begin
            BUS_A   <= pend_a;
            BUS_DO  <= pend_do;
            BUS_WE  <= pend_wr;
            BUS_REQ <= 1'b1;
            state   <= S_BUS;
            if (DSP_REQ) begin
              pend_a  <= DSP_A;
              pend_do <= DSP_DO;
              pend_wr <= DSP_WR;
            end else begin
              pend_v <= 1'b0;
            end
          end else if (DSP_REQ) begin
            BUS_A   <= DSP_A;
            BUS_DO  <= DSP_DO;
            BUS_WE  <= DSP_WR;
            BUS_REQ <= 1'b1;
            state   <= S_BUS;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scu_dsp_dma_bridge.sv
// Scoreboard bench for scu_dsp_dma_bridge; timeout scenario runs only when SCU_DSP_DMA_TIMEOUT_EN is defined.
module tb_scu_dsp_dma_bridge;

  logic        CLK = 1'b0;
  logic        RST_N, CE_R;
  logic [24:0] DSP_A;
  logic [31:0] DSP_DO;
  logic        DSP_WR, DSP_REQ;
  logic        DSP_ACK;
  logic [31:0] DSP_DI;
  logic [24:0] BUS_A;
  logic [31:0] BUS_DO;
  logic [31:0] BUS_DI;
  logic        BUS_WE, BUS_REQ, BUS_RDY, BUSY, ERR, ERR_CLR;

  scu_dsp_dma_bridge #(.WAIT_MAX(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R),
    .DSP_A(DSP_A), .DSP_DO(DSP_DO), .DSP_WR(DSP_WR), .DSP_REQ(DSP_REQ),
    .DSP_ACK(DSP_ACK), .DSP_DI(DSP_DI),
    .BUS_A(BUS_A), .BUS_DO(BUS_DO), .BUS_DI(BUS_DI), .BUS_WE(BUS_WE),
    .BUS_REQ(BUS_REQ), .BUS_RDY(BUS_RDY),
    .BUSY(BUSY), .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [24:0] a;
    logic        we;
    logic [31:0] d;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] ack_q[$];
  logic [31:0] last_rd;
  int          tests = 0;
  int          fails = 0;
  int          clk_cnt = 0;
  bit          toggle = 1'b0;

  always @(posedge CLK) clk_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one sample per CE cycle, taken on the falling edge.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && CE_R === 1'b1) begin
      if (BUS_REQ && BUS_RDY) begin : bus_mon
        bus_t e;
        if (bus_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL bus_unexpected: got addr %h we %b expected no bus cycle", BUS_A, BUS_WE);
        end else begin
          e = bus_q.pop_front();
          chk("bus_a", {7'd0, BUS_A}, {7'd0, e.a});
          chk("bus_we", {31'd0, BUS_WE}, {31'd0, e.we});
          if (e.we) chk("bus_do", BUS_DO, e.d);
        end
      end
      if (DSP_ACK) begin : ack_mon
        logic [31:0] d;
        if (ack_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ack_unexpected: got DSP_ACK=1 expected 0");
        end else begin
          d = ack_q.pop_front();
          chk("dsp_di", DSP_DI, d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
    if (toggle) begin
      CE_R = 1'b0;
      @(posedge CLK); #1;
      CE_R = 1'b1;
    end
  endtask

  task automatic exp_rd(input logic [24:0] a, input logic [31:0] d);
    bus_q.push_back('{a, 1'b0, 32'h0});
    ack_q.push_back(d);
    last_rd = d;
  endtask

  task automatic exp_wr(input logic [24:0] a, input logic [31:0] d);
    bus_q.push_back('{a, 1'b1, d});
    ack_q.push_back(last_rd);
  endtask

  task automatic issue(input logic [24:0] a, input logic wr, input logic [31:0] d);
    DSP_A = a; DSP_WR = wr; DSP_DO = d; DSP_REQ = 1'b1;
    tick();
    DSP_REQ = 1'b0;
  endtask

  task automatic read_deadbeef();
    int t0;
    t0 = clk_cnt;
    exp_rd(25'h0100000, 32'hDEADBEEF);
    issue(25'h0100000, 1'b0, 32'h0);
    chk("rd_busreq_n1", {31'd0, BUS_REQ}, 32'd1);
    chk("rd_bus_a", {7'd0, BUS_A}, 32'h0100000);
    chk("rd_bus_we", {31'd0, BUS_WE}, 32'd0);
    tick(); tick();
    chk("rd_busreq_hold", {31'd0, BUS_REQ}, 32'd1);
    BUS_DI = 32'hDEADBEEF; BUS_RDY = 1'b1;
    tick();
    BUS_RDY = 1'b0;
    chk("rd_ack", {31'd0, DSP_ACK}, 32'd1);
    chk("rd_latency", clk_cnt - t0, toggle ? 32'd8 : 32'd4);
    tick();
    chk("rd_ack_drop", {31'd0, DSP_ACK}, 32'd0);
    chk("rd_idle", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; CE_R = 1'b1; DSP_A = '0; DSP_DO = '0; DSP_WR = 1'b0; DSP_REQ = 1'b0;
    BUS_DI = '0; BUS_RDY = 1'b0; ERR_CLR = 1'b0; last_rd = '0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    chk("rst_ack",   {31'd0, DSP_ACK}, 32'd0);
    chk("rst_di",    DSP_DI, 32'd0);
    chk("rst_bus_a", {7'd0, BUS_A}, 32'd0);
    chk("rst_bus_do", BUS_DO, 32'd0);
    chk("rst_we",    {31'd0, BUS_WE}, 32'd0);
    chk("rst_req",   {31'd0, BUS_REQ}, 32'd0);
    chk("rst_busy",  {31'd0, BUSY}, 32'd0);
    chk("rst_err",   {31'd0, ERR}, 32'd0);

    read_deadbeef();

    // Chained write burst, each request issued in the ACK cycle.
    BUS_RDY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_wr(25'h200 + 25'(i), 32'(i));
      issue(25'h200 + 25'(i), 1'b1, 32'(i));
      chk("burst_busreq", {31'd0, BUS_REQ}, 32'd1);
      chk("burst_noack", {31'd0, DSP_ACK}, 32'd0);
      tick();
      chk("burst_ack", {31'd0, DSP_ACK}, 32'd1);
      chk("burst_busy", {31'd0, BUSY}, 32'd1);
    end
    BUS_RDY = 1'b0;
    tick();
    chk("burst_idle", {31'd0, BUSY}, 32'd0);

    // Pending slot, overflow error, ERR_CLR priority, ACK-time ordering.
    exp_rd(25'h300, 32'h11111111);
    issue(25'h300, 1'b0, 32'h0);
    exp_rd(25'h304, 32'h22222222);
    issue(25'h304, 1'b0, 32'h0);
    chk("pend_noerr", {31'd0, ERR}, 32'd0);
    issue(25'h308, 1'b0, 32'h0);
    chk("drop_err", {31'd0, ERR}, 32'd1);
    ERR_CLR = 1'b1;
    issue(25'h30A, 1'b0, 32'h0);
    ERR_CLR = 1'b0;
    chk("err_clr_vs_set", {31'd0, ERR}, 32'd1);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("err_cleared", {31'd0, ERR}, 32'd0);
    BUS_DI = 32'h11111111; BUS_RDY = 1'b1;
    tick();
    BUS_RDY = 1'b0;
    chk("pend_ack1", {31'd0, DSP_ACK}, 32'd1);
    exp_rd(25'h30C, 32'h33333333);
    issue(25'h30C, 1'b0, 32'h0);
    chk("pend_served_a", {7'd0, BUS_A}, 32'h304);
    chk("pend_busy", {31'd0, BUSY}, 32'd1);
    BUS_DI = 32'h22222222; BUS_RDY = 1'b1;
    tick();
    BUS_RDY = 1'b0;
    chk("pend_ack2", {31'd0, DSP_ACK}, 32'd1);
    tick();
    chk("pend_next_a", {7'd0, BUS_A}, 32'h30C);
    BUS_DI = 32'h33333333; BUS_RDY = 1'b1;
    tick();
    BUS_RDY = 1'b0;
    tick();
    chk("pend_idle", {31'd0, BUSY}, 32'd0);

`ifdef SCU_DSP_DMA_TIMEOUT_EN
    ack_q.push_back(32'hFFFFFFFF);
    last_rd = 32'hFFFFFFFF;
    issue(25'h500, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("tmo_wait", {31'd0, BUS_REQ}, 32'd1);
    end
    tick();
    chk("tmo_drop", {31'd0, BUS_REQ}, 32'd0);
    chk("tmo_ack", {31'd0, DSP_ACK}, 32'd1);
    chk("tmo_err", {31'd0, ERR}, 32'd1);
    tick();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
`endif

    // Asynchronous reset in the middle of a bus cycle.
    issue(25'h400, 1'b0, 32'h0);
    chk("arst_pre", {31'd0, BUS_REQ}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_busreq", {31'd0, BUS_REQ}, 32'd0);
    chk("arst_busy", {31'd0, BUSY}, 32'd0);
    RST_N = 1'b1;
    last_rd = '0;
    BUS_RDY = 1'b1;
    tick(); tick();
    BUS_RDY = 1'b0;
    chk("arst_noack", {31'd0, DSP_ACK}, 32'd0);
    chk("arst_di", DSP_DI, 32'd0);
    exp_rd(25'h404, 32'h44444444);
    BUS_DI = 32'h44444444; BUS_RDY = 1'b1;
    issue(25'h404, 1'b0, 32'h0);
    tick();
    BUS_RDY = 1'b0;
    chk("arst_next_ack", {31'd0, DSP_ACK}, 32'd1);
    tick();

    // Same read with CE_R toggling 1:1.
    toggle = 1'b1;
    read_deadbeef();
    toggle = 1'b0;
    tick();

    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("ack_q_empty", ack_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
